video_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed 800x600@60 frame generator used by the squares/background display path.
- Produces hsync/vsync, videoActive, pixel/line positions, line strobes and next-line lookahead for SRAM-prefetching layers.
- Adds the following over the fixed generator:
  - configurable mode timing and sync polarity;
  - runtime enable;
  - frame counter and frame/vblank strobes;
  - asynchronous reset.
- Sits between the pixel clock and all layer/compositor blocks.

---
 rtl/video_timing_gen.sv | 156 +++++++++++++++
 tb/tb_video_timing_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator.
// Free-running pixel/line counters gated by a run enable. Visible and sync
// flags pass through a configurable delay line. Line and frame strobes are
// registered so that they line up with the counters.
module video_timing_gen #(
  parameter int H_ACTIVE       = 800,
  parameter int H_FP           = 40,
  parameter int H_SYNC         = 128,
  parameter int H_BP           = 88,
  parameter int V_ACTIVE       = 600,
  parameter int V_FP           = 1,
  parameter int V_SYNC         = 4,
  parameter int V_BP           = 23,
  parameter bit HSYNC_POL      = 1'b1,
  parameter bit VSYNC_POL      = 1'b1,
  parameter int PIPELINE_DELAY = 1,
  parameter int POS_W          = 11,
  parameter int FRAME_W        = 16
) (
  input  logic               clk40,
  input  logic               rst,
  input  logic               en,
  output logic [POS_W-1:0]   hPos,
  output logic [POS_W-1:0]   vPos,
  output logic [POS_W-1:0]   nextVPos,
  output logic               nextFrameActive,
  output logic               lineStarting,
  output logic               lineEnding,
  output logic               frameStart,
  output logic               vblankStart,
  output logic               videoActive,
  output logic               hsync,
  output logic               vsync,
  output logic [FRAME_W-1:0] frameCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] H_LAST     = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_ACT      = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_ACT      = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] H_SYNC_BEG = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] H_SYNC_END = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] V_SYNC_BEG = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] V_SYNC_END = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  // Reject timing sets the counters cannot represent.
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_porch
    $error("video_timing_gen: porch and sync widths must be at least 1");
  end
  if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : g_err_width
    $error("video_timing_gen: POS_W too small for H_TOTAL/V_TOTAL");
  end
  if (PIPELINE_DELAY < 0 || PIPELINE_DELAY > 8) begin : g_err_delay
    $error("video_timing_gen: PIPELINE_DELAY must be 0..8");
  end

  logic [POS_W-1:0]   r_hpos;
  logic [POS_W-1:0]   r_vpos;
  logic [FRAME_W-1:0] r_frame_count;
  logic               r_line_starting;
  logic               r_line_ending;
  logic               r_frame_start;
  logic               r_vblank_start;

  logic               w_h_wrap;
  logic               w_v_wrap;
  logic [POS_W-1:0]   w_hpos_next;
  logic [POS_W-1:0]   w_vpos_inc;
  logic [POS_W-1:0]   w_vpos_next;
  logic               w_act;
  logic               w_hs;
  logic               w_vs;
  logic [2:0]         w_raw;
  logic [2:0]         w_dly;

  assign w_h_wrap    = (r_hpos == H_LAST);
  assign w_v_wrap    = (r_vpos == V_LAST);
  assign w_hpos_next = w_h_wrap ? '0 : r_hpos + 1'b1;
  assign w_vpos_inc  = w_v_wrap ? '0 : r_vpos + 1'b1;
  assign w_vpos_next = w_h_wrap ? w_vpos_inc : r_vpos;

  // Raw region flags from the current counters; all inactive while stopped.
  assign w_act = (r_hpos < H_ACT) && (r_vpos < V_ACT) && en;
  assign w_hs  = (r_hpos >= H_SYNC_BEG) && (r_hpos < H_SYNC_END) && en;
  assign w_vs  = (r_vpos >= V_SYNC_BEG) && (r_vpos < V_SYNC_END) && en;
  assign w_raw = {w_act, w_hs, w_vs};

  // Position and frame counters advance only while enabled.
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_frame_count <= '0;
    end else if (en) begin
      r_hpos <= w_hpos_next;
      r_vpos <= w_vpos_next;
      if (w_h_wrap && w_v_wrap) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  // Strobes describe the position being entered, so they hold with the counters.
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      r_line_starting <= 1'b0;
      r_line_ending   <= 1'b0;
      r_frame_start   <= 1'b0;
      r_vblank_start  <= 1'b0;
    end else if (en) begin
      r_line_starting <= (w_hpos_next == '0);
      r_line_ending   <= (w_hpos_next == H_ACT);
      r_frame_start   <= (w_hpos_next == '0) && (w_vpos_next == '0);
      r_vblank_start  <= (w_hpos_next == '0) && (w_vpos_next == V_ACT);
    end
  end

  if (PIPELINE_DELAY == 0) begin : g_no_pipe
    assign w_dly = w_raw;
  end else begin : g_pipe
    logic [2:0] r_stage [PIPELINE_DELAY];

    // Delay line shifts every clock so it drains cleanly when disabled.
    always_ff @(posedge clk40 or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPELINE_DELAY; i++) begin
          r_stage[i] <= '0;
        end
      end else begin
        r_stage[0] <= w_raw;
        for (int i = 1; i < PIPELINE_DELAY; i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign w_dly = r_stage[PIPELINE_DELAY-1];
  end

  assign hPos            = r_hpos;
  assign vPos            = r_vpos;
  assign nextVPos        = w_vpos_inc;
  assign nextFrameActive = (w_vpos_inc < V_ACT);
  assign lineStarting    = r_line_starting;
  assign lineEnding      = r_line_ending;
  assign frameStart      = r_frame_start;
  assign vblankStart     = r_vblank_start;
  assign frameCount      = r_frame_count;
  assign videoActive     = w_dly[2];
  assign hsync           = ~(w_dly[1] ^ HSYNC_POL);
  assign vsync           = ~(w_dly[0] ^ VSYNC_POL);

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen with a small mode (H 8/2/3/1,
// V 4/1/2/1), two-stage delay and active-low syncs.
module tb_video_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic [10:0] nv;
    logic        nfa;
    logic        ls;
    logic        le;
    logic        fs;
    logic        vb;
    logic        va;
    logic        hs;
    logic        vs;
    logic [15:0] fc;
  } obs_t;

  logic        clk40 = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b0;
  logic [10:0] hPos, vPos, nextVPos;
  logic        nextFrameActive, lineStarting, lineEnding, frameStart, vblankStart;
  logic        videoActive, hsync, vsync;
  logic [15:0] frameCount;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .PIPELINE_DELAY(2), .POS_W(11), .FRAME_W(16)
  ) u_dut (
    .clk40(clk40), .rst(rst), .en(en),
    .hPos(hPos), .vPos(vPos), .nextVPos(nextVPos),
    .nextFrameActive(nextFrameActive),
    .lineStarting(lineStarting), .lineEnding(lineEnding),
    .frameStart(frameStart), .vblankStart(vblankStart),
    .videoActive(videoActive), .hsync(hsync), .vsync(vsync),
    .frameCount(frameCount)
  );

  always #5 clk40 = ~clk40;

  int   tests = 0;
  int   fails = 0;
  obs_t exp_q [$];

  // Reference: t counts enabled edges since reset; positions derive from it.
  int       t = 0;
  logic [2:0] hist1 = '0;
  logic [2:0] hist2 = '0;

  function automatic logic [2:0] raw_of(input int tt, input bit en_v);
    int h, v;
    h = tt % 14;
    v = (tt / 14) % 8;
    return {en_v && h < 8 && v < 4, en_v && h >= 10 && h < 13, en_v && v >= 5 && v < 7};
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    int h, v, nv;
    h = t % 14;
    v = (t / 14) % 8;
    nv = (v == 7) ? 0 : v + 1;
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.nv  = 11'(nv);
    e.nfa = (nv < 4);
    e.ls  = (t > 0) && (h == 0);
    e.le  = (t > 0) && (h == 8);
    e.fs  = (t > 0) && (h == 0) && (v == 0);
    e.vb  = (t > 0) && (h == 0) && (v == 4);
    e.va  = hist2[2];
    e.hs  = ~hist2[1];
    e.vs  = ~hist2[0];
    e.fc  = 16'(t / 112);
    return e;
  endfunction

  task automatic model_edge(input bit en_v);
    hist2 = hist1;
    hist1 = raw_of(t, en_v);
    if (en_v) t = t + 1;
  endtask

  task automatic model_reset();
    t = 0;
    hist1 = '0;
    hist2 = '0;
  endtask

  task automatic cycle(input bit en_v);
    en = en_v;
    @(posedge clk40);
    #1;
    model_edge(en_v);
    exp_q.push_back(model_out());
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    @(posedge clk40);
    #1;
    model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor statistics, derived from observed outputs only.
  int cyc = 0;
  int last_fs = -1;
  int low_run = 0;
  int act_cnt = 0;
  bit seen_fs = 1'b0;
  int intervals [$];

  // Monitor: pop one expectation per cycle and compare on the falling edge.
  initial begin
    obs_t got, e;
    forever begin
      @(negedge clk40);
      cyc++;
      got = {hPos, vPos, nextVPos, nextFrameActive, lineStarting, lineEnding,
             frameStart, vblankStart, videoActive, hsync, vsync, frameCount};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
          fails++;
          $display("[TB] FAIL cyc%0d outputs: got h=%0d v=%0d nv=%0d nfa=%b ls=%b le=%b fs=%b vb=%b va=%b hs=%b vs=%b fc=%0d, need h=%0d v=%0d nv=%0d nfa=%b ls=%b le=%b fs=%b vb=%b va=%b hs=%b vs=%b fc=%0d",
                   cyc, got.h, got.v, got.nv, got.nfa, got.ls, got.le, got.fs, got.vb, got.va, got.hs, got.vs, got.fc,
                   e.h, e.v, e.nv, e.nfa, e.ls, e.le, e.fs, e.vb, e.va, e.hs, e.vs, e.fc);
        end else begin
          $display("[TB] cyc%0d ok rst=%b en=%b h=%0d v=%0d va=%b hs=%b vs=%b fc=%0d",
                   cyc, rst, en, got.h, got.v, got.va, got.hs, got.vs, got.fc);
        end
      end
      if (rst) begin
        last_fs = -1;
        low_run = 0;
      end
      if (!hsync) begin
        low_run++;
      end else begin
        if (low_run > 0) begin
          tests++;
          if (low_run != 3) begin
            fails++;
            $display("[TB] FAIL hsync_width: got %0d cycles, need 3", low_run);
          end
        end
        low_run = 0;
      end
      if (!seen_fs && videoActive) act_cnt++;
      if (frameStart) begin
        seen_fs = 1'b1;
        if (last_fs >= 0) intervals.push_back(cyc - last_fs);
        last_fs = cyc;
      end
    end
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, need finish before 200000ns");
    $fatal(1, "timeout");
  end

  // Stimulus: reset, two frames, en gap at (5,2), async reset mid-hsync.
  initial begin
    int exp_iv [2];
    exp_iv[0] = 112;
    exp_iv[1] = 122;
    repeat (3) rst_cycle();
    rst = 1'b0;
    repeat (257) cycle(1'b1);
    repeat (10) cycle(1'b0);
    repeat (159) cycle(1'b1);
    // Edge lands on (11,5); reset is then raised between clock edges.
    en = 1'b1;
    @(posedge clk40);
    #1;
    model_edge(1'b1);
    #1;
    rst = 1'b1;
    model_reset();
    exp_q.push_back(model_out());
    repeat (2) rst_cycle();
    rst = 1'b0;
    repeat (116) cycle(1'b1);
    en = 1'b0;
    @(negedge clk40);
    @(negedge clk40);

    tests++;
    if (act_cnt != 32) begin
      fails++;
      $display("[TB] FAIL active_pixels: got %0d, need 32", act_cnt);
    end
    tests++;
    if (intervals.size() != 2) begin
      fails++;
      $display("[TB] FAIL frame_interval_count: got %0d, need 2", intervals.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (intervals[i] != exp_iv[i]) begin
          fails++;
          $display("[TB] FAIL frame_period%0d: got %0d, need %0d", i, intervals[i], exp_iv[i]);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d left, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
